// File: rtl/div_seq.sv
// Iterative RV32M DIV/DIVU/REM/REMU sequencer: 32-step restoring division,
// one quotient bit per cycle, with pipeline stall request and one-cycle ready pulse.
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        annul_i,
    output logic [31:0] result_o,
    output logic        ready_o,
    output logic        stall_req_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q, state_d;
    logic        is_rem_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic [32:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [4:0]  cnt_q;

    logic        is_signed, sd, ss;
    logic [31:0] abs_dvd, abs_dvs;
    logic        div_zero, ovf, special, accept;
    logic [31:0] special_res;

    always_comb begin
        is_signed   = ~op_i[0];
        sd          = is_signed & dividend_i[31];
        ss          = is_signed & divisor_i[31];
        abs_dvd     = sd ? -dividend_i : dividend_i;
        abs_dvs     = ss ? -divisor_i : divisor_i;
        div_zero    = (divisor_i == 32'd0);
        ovf         = is_signed && (dividend_i == 32'h8000_0000) &&
                      (divisor_i == 32'hFFFF_FFFF);
        special     = div_zero | ovf;
        accept      = (state_q == StIdle) && start_i && !annul_i;
        special_res = 32'd0;
        if (div_zero) begin
            special_res = op_i[1] ? dividend_i : 32'hFFFF_FFFF;
        end else begin
            special_res = op_i[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One restoring step; the quotient register doubles as the dividend shifter.
    logic [33:0] shifted, diff;
    logic        take;
    logic [32:0] rem_nxt;
    logic [31:0] quo_nxt, q_fix, r_fix, final_res;

    always_comb begin
        shifted   = {rem_q, quo_q[31]};
        diff      = shifted - {2'b00, dvs_q};
        take      = ~diff[33];
        rem_nxt   = take ? diff[32:0] : shifted[32:0];
        quo_nxt   = {quo_q[30:0], take};
        q_fix     = q_neg_q ? -quo_nxt : quo_nxt;
        r_fix     = r_neg_q ? -rem_nxt[31:0] : rem_nxt[31:0];
        final_res = is_rem_q ? r_fix : q_fix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = special ? StDone : StCalc;
            StCalc:  if (cnt_q == 5'd31) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (annul_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            rem_q    <= 33'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            cnt_q    <= 5'd0;
            result_o <= 32'd0;
        end else if (accept) begin
            is_rem_q <= op_i[1];
            q_neg_q  <= sd ^ ss;
            r_neg_q  <= sd;
            rem_q    <= 33'd0;
            quo_q    <= abs_dvd;
            dvs_q    <= abs_dvs;
            cnt_q    <= 5'd0;
            if (special) begin
                result_o <= special_res;
            end
        end else if (state_q == StCalc && !annul_i) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                result_o <= final_res;
            end
        end
    end

    assign ready_o     = (state_q == StDone);
    assign busy_o      = (state_q != StIdle);
    assign stall_req_o = accept || (state_q == StCalc);

endmodule
